// File: rtl/vga_sync_gen_if.sv
// Raster timing bundle between vga_sync_gen and the sprite drawer stages.
// master: the timing generator drives every signal; slave: the drawers read them.
interface vga_sync_gen_if;
  logic       pix_en;
  logic [9:0] hcount;
  logic [9:0] vcount;
  logic       hsync;
  logic       vsync;
  logic       video_on;
  logic       line_start;
  logic       frame_start;
  logic [7:0] frame_count;

  modport master (
    output pix_en, hcount, vcount, hsync, vsync, video_on,
           line_start, frame_start, frame_count
  );

  modport slave (
    input  pix_en, hcount, vcount, hsync, vsync, video_on,
           line_start, frame_start, frame_count
  );
endinterface

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA raster timing generator.
// Divides clk into a pixel strobe, walks hcount/vcount across the raster and
// produces hsync/vsync, video_on and line/frame start pulses, all registered
// and aligned with the coordinate they describe.
// Optional: define VGA_FRAME_COUNT_EN to get a modulo-256 frame counter;
// otherwise frame_count is tied to zero.
module vga_sync_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned SYNC_POL = 0
) (
  input  logic            clk,
  input  logic            reset,
  vga_sync_gen_if.master  vga
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  localparam int unsigned         DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic                SYNC_ACT = (SYNC_POL != 0);

  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] div_nxt;
  logic             adv;
  logic [9:0]       hcnt;
  logic [9:0]       vcnt;
  logic [9:0]       h_nxt;
  logic [9:0]       v_nxt;
  logic             pix_en_r;
  logic             hsync_r;
  logic             vsync_r;
  logic             video_on_r;
  logic             line_start_r;
  logic             frame_start_r;

  // Next divider/coordinate values; flags are decoded from these so they
  // line up with the coordinate registered on the same edge.
  always_comb begin
    div_nxt = (div == DIV_LAST) ? '0 : div + 1'b1;
    adv     = (div_nxt == DIV_LAST);
    h_nxt   = hcnt;
    v_nxt   = vcnt;
    if (adv) begin
      if (hcnt == H_LAST) begin
        h_nxt = '0;
        v_nxt = (vcnt == V_LAST) ? '0 : vcnt + 10'd1;
      end else begin
        h_nxt = hcnt + 10'd1;
      end
    end
  end

  // Divider, counters and registered raster flags; flags only update on a
  // pixel advance so the post-reset (0,0) stays blanked until the first strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      div           <= '0;
      pix_en_r      <= 1'b0;
      hcnt          <= '0;
      vcnt          <= '0;
      hsync_r       <= ~SYNC_ACT;
      vsync_r       <= ~SYNC_ACT;
      video_on_r    <= 1'b0;
      line_start_r  <= 1'b0;
      frame_start_r <= 1'b0;
    end else begin
      div           <= div_nxt;
      pix_en_r      <= adv;
      line_start_r  <= 1'b0;
      frame_start_r <= 1'b0;
      if (adv) begin
        hcnt          <= h_nxt;
        vcnt          <= v_nxt;
        hsync_r       <= (h_nxt >= HS_START && h_nxt < HS_END) ? SYNC_ACT : ~SYNC_ACT;
        vsync_r       <= (v_nxt >= VS_START && v_nxt < VS_END) ? SYNC_ACT : ~SYNC_ACT;
        video_on_r    <= (h_nxt < H_ACT) && (v_nxt < V_ACT);
        line_start_r  <= (h_nxt == '0);
        frame_start_r <= (h_nxt == '0) && (v_nxt == '0);
      end
    end
  end

`ifdef VGA_FRAME_COUNT_EN
  logic [7:0] fcnt;

  // Count completed frames, wrapping naturally at 256.
  always_ff @(posedge clk) begin
    if (reset) begin
      fcnt <= '0;
    end else if (frame_start_r) begin
      fcnt <= fcnt + 8'd1;
    end
  end

  assign vga.frame_count = fcnt;
`else
  assign vga.frame_count = '0;
`endif

  assign vga.pix_en      = pix_en_r;
  assign vga.hcount      = hcnt;
  assign vga.vcount      = vcnt;
  assign vga.hsync       = hsync_r;
  assign vga.vsync       = vsync_r;
  assign vga.video_on    = video_on_r;
  assign vga.line_start  = line_start_r;
  assign vga.frame_start = frame_start_r;

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
Raster timing generator for the VGA path.
- Divides the system clock into a pixel-rate strobe.
- Produces the hcount/vcount pixel coordinates consumed by the sprite drawer stages (ducks, background, crosshair).
- Generates hsync/vsync, the active-video flag, and line/frame start pulses that downstream drawers use to rewind their ROM address counters.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- CLK_DIV, 2, system clocks per pixel (>=1)
- SYNC_POL, 0, active level of hsync/vsync (0 = active-low)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- pix_en  out  1  one-clk strobe per pixel period
- hcount  out  10  current column, 0..H_TOTAL-1
- vcount  out  10  current line, 0..V_TOTAL-1
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- video_on  out  1  high while (hcount,vcount) is in the active area
- line_start  out  1  one-clk pulse when hcount becomes 0
- frame_start  out  1  one-clk pulse when (hcount,vcount) becomes (0,0)
- frame_count  out  8  frames completed, modulo 256

Behaviour:
- One clock domain (clk); reset is synchronous, active-high, sampled on every rising edge and overriding all other activity.
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800; V_TOTAL = 525 with defaults.
- Divider: div counts 0..CLK_DIV-1, wraps to 0. pix_en is registered and high for exactly the one clk in which div==CLK_DIV-1. With CLK_DIV=1, pix_en is constantly high after reset.
- Counter advance happens only on clocks where pix_en is high:
  - hcount <= hcount+1.
  - If hcount==H_TOTAL-1: hcount <= 0 and vcount <= vcount+1.
  - If additionally vcount==V_TOTAL-1: vcount <= 0.
  - Counters never exceed TOTAL-1.
- All outputs are registered and decoded from the next counter values, so hsync, vsync, video_on and the pulses are aligned with the hcount/vcount they describe. No added latency between coordinate and flags.
- hsync is at the active level iff H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC (656..751); otherwise inactive.
- vsync is at the active level iff V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC (490..491).
- video_on = (hcount < H_ACTIVE) && (vcount < V_ACTIVE).
- line_start: high for one clk, in the same clk that hcount changes to 0.
- frame_start: high for one clk, in the same clk that both counters change to 0. Also raises line_start.
- Reset values: div=0, pix_en=0, hcount=0, vcount=0, hsync=vsync=inactive (~SYNC_POL), video_on=0, line_start=0, frame_start=0, frame_count=0.
  - Position (0,0) of the first frame after reset is therefore blanked and unflagged.
  - Normal decode starts at the first pix_en.
- Reset mid-frame: the next edge forces the reset values regardless of position. No partial sync pulse is extended.
- Parameter-derived compare constants are computed at elaboration. All counter arithmetic is 10-bit unsigned; every default total is < 1024.

Optional Feature:
- Macro: VGA_FRAME_COUNT_EN.
- Defined: frame_count increments by 1 on each clk with frame_start high, wrapping 255 -> 0; cleared by reset.
- Undefined: frame_count tied to 8'd0 and no counter register is synthesized. All other behaviour is identical.

Test Plan:
- Reset held 5 clks -> hcount=0, vcount=0, hsync=vsync=1, video_on=0, pix_en=0. After release, pix_en high every 2nd clk, hcount reaches 1 at the first pix_en.
- Free run with defaults -> frame_start pulses exactly 840000 clks apart (800*525*2); line_start pulses 1600 clks apart.
- Within one line -> hsync=0 for exactly 96 pix_en periods, starting at hcount=656, back to 1 at 752. vsync=0 only while vcount is 490 or 491.
- Second full frame -> video_on high for exactly 307200 pix_en periods. video_on=0 at hcount=640, and at vcount=480 for every hcount.
- Reset asserted one clk at hcount=300, vcount=200 -> next edge: hcount=0, vcount=0, frame_count=0, no frame_start pulse.
- VGA_FRAME_COUNT_EN defined -> frame_count=3 after 3 frame_starts and 0 after 256. Undefined -> frame_count stays 0 throughout.
